// File: rtl/instr_decode_ctrl.sv
// Instruction decode and sequencing control for a single-issue 24-bit ISA.
// Drives datapath enables combinationally; tracks LD writeback, HALT, Z flag and a PC shadow.
module instr_decode_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic [23:0] instr,
  input  logic        alu_zero,
  output logic        PCSrc,
  output logic [7:0]  immediate,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [7:0]  imm_data,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        wb_sel,
  output logic        halted,
  output logic [7:0]  pc_shadow
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD_WB = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  state_e      state_q, state_d;
  logic        z_flag_q, z_flag_d;
  logic [7:0]  pc_q, pc_d;
  logic [3:0]  opcode_s;

  assign opcode_s  = instr[23:20];
  assign rd_addr   = instr[19:16];
  assign rs_addr   = instr[15:12];
  assign rt_addr   = instr[11:8];
  assign imm_data  = instr[7:0];
  assign halted    = (state_q == ST_HALT);
  assign pc_shadow = pc_q;

  // Decode: control outputs and next-state values
  always_comb begin
    PCSrc       = 1'b0;
    immediate   = instr[7:0];
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    wb_sel      = 1'b0;
    state_d     = state_q;
    z_flag_d    = z_flag_q;
    // Outputs stay quiet while reset is held even though state already reads RUN
    if (reset) begin
      state_d  = ST_RUN;
      z_flag_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          case (opcode_s)
            OP_ADD: begin
              reg_we = 1'b1;
            end
            OP_SUB: begin
              alu_op   = ALU_SUB;
              reg_we   = 1'b1;
              z_flag_d = alu_zero;
            end
            OP_ADDI: begin
              alu_src_imm = 1'b1;
              reg_we      = 1'b1;
            end
            OP_LD: begin
              mem_re    = 1'b1;
              PCSrc     = 1'b1;
              immediate = pc_q;
              state_d   = ST_LOAD_WB;
            end
            OP_ST: begin
              mem_we = 1'b1;
              alu_op = ALU_PASS;
            end
            OP_JMP: begin
              PCSrc = 1'b1;
            end
            OP_BEQ: begin
              PCSrc = z_flag_q;
            end
            OP_BNE: begin
              PCSrc = ~z_flag_q;
            end
            OP_CMP: begin
              alu_op   = ALU_SUB;
              z_flag_d = alu_zero;
            end
            OP_HALT: begin
              PCSrc     = 1'b1;
              immediate = pc_q;
              state_d   = ST_HALT;
            end
            default: begin
              state_d = ST_RUN;
            end
          endcase
        end
        // Writeback completes regardless of what the ROM re-presents
        ST_LOAD_WB: begin
          mem_re  = 1'b1;
          wb_sel  = 1'b1;
          reg_we  = 1'b1;
          state_d = ST_RUN;
        end
        ST_HALT: begin
          PCSrc     = 1'b1;
          immediate = pc_q;
          state_d   = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    pc_d = PCSrc ? immediate : (pc_q + 8'd1);
  end

  // State, Z flag and PC shadow registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      z_flag_q <= 1'b0;
      pc_q     <= 8'd0;
    end else begin
      state_q  <= state_d;
      z_flag_q <= z_flag_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Self-checking bench for instr_decode_ctrl: directed program with literal expectations
// plus a behavioural model compared against the DUT every cycle.
module tb_instr_decode_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [23:0] instr;
  logic        alu_zero;
  logic        PCSrc;
  logic [7:0]  immediate;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic [7:0]  imm_data;
  logic [1:0]  alu_op;
  logic        alu_src_imm, reg_we, mem_re, mem_we, wb_sel;
  logic        halted;
  logic [7:0]  pc_shadow;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  instr_decode_ctrl dut (
    .CLK(CLK), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .PCSrc(PCSrc), .immediate(immediate),
    .rd_addr(rd_addr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .imm_data(imm_data), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .wb_sel(wb_sel),
    .halted(halted), .pc_shadow(pc_shadow)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcsrc;
    logic [7:0] imm;
    logic [1:0] aluop;
    logic       src, we, re, mwe, wb;
  } ctl_t;

  // Behavioural model: architectural PC, Z flag, pending LD writeback, halted
  int m_pc   = 0;
  bit m_z    = 1'b0;
  bit m_wb   = 1'b0;
  bit m_halt = 1'b0;
  ctl_t ce, cn;

  function automatic ctl_t spec_ctl(input logic [23:0] i, input bit rst, input bit wb,
                                    input bit hlt, input bit z, input int pc);
    ctl_t c;
    c = '0;
    c.imm = i[7:0];
    if (rst) return '0;
    if (hlt) begin c.pcsrc = 1'b1; c.imm = 8'(pc); return c; end
    if (wb)  begin c.re = 1'b1; c.wb = 1'b1; c.we = 1'b1; return c; end
    case (i[23:20])
      4'h1: c.we = 1'b1;
      4'h2: begin c.aluop = 2'b01; c.we = 1'b1; end
      4'h3: begin c.src = 1'b1; c.we = 1'b1; end
      4'h4: begin c.re = 1'b1; c.pcsrc = 1'b1; c.imm = 8'(pc); end
      4'h5: begin c.mwe = 1'b1; c.aluop = 2'b10; end
      4'h6: c.pcsrc = 1'b1;
      4'h7: c.pcsrc = z;
      4'h8: c.pcsrc = !z;
      4'h9: c.aluop = 2'b01;
      4'hF: begin c.pcsrc = 1'b1; c.imm = 8'(pc); end
      default: c.pcsrc = 1'b0;
    endcase
    return c;
  endfunction

  task automatic cmp8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    cmp8(name, 8'(act), 8'(exp));
  endtask

  // Model state update, async reset like the DUT
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_pc <= 0; m_z <= 1'b0; m_wb <= 1'b0; m_halt <= 1'b0;
    end else begin
      cn = spec_ctl(instr, 1'b0, m_wb, m_halt, m_z, m_pc);
      if (!m_halt) begin
        if (m_wb) begin
          m_wb <= 1'b0;
        end else begin
          if (instr[23:20] == 4'h2 || instr[23:20] == 4'h9) m_z <= alu_zero;
          m_wb   <= (instr[23:20] == 4'h4);
          m_halt <= (instr[23:20] == 4'hF);
        end
      end
      m_pc <= cn.pcsrc ? int'(cn.imm) : (m_pc + 1) % 256;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      ce = spec_ctl(instr, reset, m_wb, m_halt, m_z, m_pc);
      cmp1("m_PCSrc", PCSrc, ce.pcsrc);
      if (ce.pcsrc) cmp8("m_immediate", immediate, ce.imm);
      cmp8("m_alu_op", 8'(alu_op), 8'(ce.aluop));
      cmp1("m_alu_src_imm", alu_src_imm, ce.src);
      cmp1("m_reg_we", reg_we, ce.we);
      cmp1("m_mem_re", mem_re, ce.re);
      cmp1("m_mem_we", mem_we, ce.mwe);
      cmp1("m_wb_sel", wb_sel, ce.wb);
      cmp8("m_pc_shadow", pc_shadow, 8'(m_pc));
      cmp1("m_halted", halted, m_halt);
      cmp8("m_rd_addr", 8'(rd_addr), 8'(instr[19:16]));
      cmp8("m_rs_addr", 8'(rs_addr), 8'(instr[15:12]));
      cmp8("m_rt_addr", 8'(rt_addr), 8'(instr[11:8]));
      cmp8("m_imm_data", imm_data, instr[7:0]);
    end
  end

  task automatic put(input logic [23:0] i, input logic az);
    instr = i; alu_zero = az; #2;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    reset = 1'b0; instr = 24'h430000; alu_zero = 1'b0;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    cmp8("rst_pc", pc_shadow, 8'h00);
    cmp1("rst_halted", halted, 1'b0);
    cmp1("rst_PCSrc", PCSrc, 1'b0);
    cmp1("rst_mem_re", mem_re, 1'b0);
    reset = 1'b0;

    // ADDI r1,5 then ADD
    put(24'h310005, 1'b0);
    cmp1("addi_we", reg_we, 1'b1); cmp1("addi_src", alu_src_imm, 1'b1);
    cmp8("addi_imm", imm_data, 8'h05); cmp8("addi_rd", 8'(rd_addr), 8'h01);
    tick(); cmp8("pc_after_addi", pc_shadow, 8'h01);
    put(24'h121100, 1'b0);
    cmp1("add_we", reg_we, 1'b1); cmp1("add_src", alu_src_imm, 1'b0);
    cmp8("add_rs", 8'(rs_addr), 8'h01); cmp8("add_rt", 8'(rt_addr), 8'h01);
    tick(); cmp8("pc_after_add", pc_shadow, 8'h02);
    put(24'h000000, 1'b0); tick(); cmp8("pc_nop", pc_shadow, 8'h03);

    // LD at address 3: two cycles
    put(24'h430010, 1'b0);
    cmp1("ldA_re", mem_re, 1'b1); cmp1("ldA_pcsrc", PCSrc, 1'b1);
    cmp8("ldA_imm", immediate, 8'h03); cmp1("ldA_we", reg_we, 1'b0);
    tick(); cmp8("pc_ldA", pc_shadow, 8'h03);
    cmp1("ldB_we", reg_we, 1'b1); cmp1("ldB_wbsel", wb_sel, 1'b1);
    cmp1("ldB_pcsrc", PCSrc, 1'b0);
    tick(); cmp8("pc_ldB", pc_shadow, 8'h04);

    // CMP/BEQ/BNE/SUB
    put(24'h900000, 1'b1);
    cmp8("cmp_aluop", 8'(alu_op), 8'h01); cmp1("cmp_we", reg_we, 1'b0);
    tick(); cmp8("pc_cmp", pc_shadow, 8'h05);
    put(24'h700040, 1'b0); cmp1("beq_taken", PCSrc, 1'b1);
    tick(); cmp8("pc_beq_taken", pc_shadow, 8'h40);
    put(24'h900000, 1'b0); tick(); cmp8("pc_cmp0", pc_shadow, 8'h41);
    put(24'h700040, 1'b0); cmp1("beq_not", PCSrc, 1'b0);
    tick(); cmp8("pc_beq_not", pc_shadow, 8'h42);
    put(24'h800080, 1'b0); cmp1("bne_taken", PCSrc, 1'b1);
    tick(); cmp8("pc_bne_taken", pc_shadow, 8'h80);
    put(24'h212300, 1'b1);
    cmp8("sub_aluop", 8'(alu_op), 8'h01); cmp1("sub_we", reg_we, 1'b1);
    tick(); cmp8("pc_sub", pc_shadow, 8'h81);
    put(24'h800010, 1'b0); cmp1("bne_not", PCSrc, 1'b0);
    tick(); cmp8("pc_bne_not", pc_shadow, 8'h82);
    put(24'h500000, 1'b0);
    cmp1("st_we", mem_we, 1'b1); cmp8("st_aluop", 8'(alu_op), 8'h02);
    cmp1("st_rwe", reg_we, 1'b0);
    tick(); cmp8("pc_st", pc_shadow, 8'h83);

    // Wrap at 0xFF by JMP and by NOP
    put(24'h6000FF, 1'b0); tick(); cmp8("pc_jmp_ff", pc_shadow, 8'hFF);
    put(24'h000000, 1'b0); tick(); cmp8("pc_nop_wrap", pc_shadow, 8'h00);
    put(24'h6000FF, 1'b0); tick(); cmp8("pc_jmp_ff2", pc_shadow, 8'hFF);
    put(24'h600000, 1'b0); tick(); cmp8("pc_jmp_00", pc_shadow, 8'h00);

    // Opcode A as NOP, self-loop, corrupt writeback
    put(24'hA12345, 1'b0);
    cmp1("opA_pcsrc", PCSrc, 1'b0); cmp1("opA_we", reg_we, 1'b0);
    cmp1("opA_mwe", mem_we, 1'b0); cmp8("opA_aluop", 8'(alu_op), 8'h00);
    tick(); cmp8("pc_opA", pc_shadow, 8'h01);
    put(24'h600001, 1'b0); cmp8("self_imm", immediate, 8'h01);
    tick(); cmp8("pc_self", pc_shadow, 8'h01);
    put(24'h450000, 1'b0); tick(); cmp8("pc_ld2A", pc_shadow, 8'h01);
    put(24'h310005, 1'b0);
    cmp1("corrupt_we", reg_we, 1'b1); cmp1("corrupt_wbsel", wb_sel, 1'b1);
    cmp1("corrupt_src", alu_src_imm, 1'b0);
    tick(); cmp8("pc_corrupt", pc_shadow, 8'h02);

    // HALT at 0x10
    put(24'h600010, 1'b0); tick(); cmp8("pc_to_halt", pc_shadow, 8'h10);
    put(24'hF00000, 1'b0); cmp1("halt_pcsrc", PCSrc, 1'b1);
    tick(); cmp1("halted_set", halted, 1'b1);
    for (int k = 0; k < 22; k++) begin
      put((k % 2 == 0) ? 24'h121100 : 24'h430000, 1'b1);
      cmp1("halt_hold_pcsrc", PCSrc, 1'b1); cmp8("halt_hold_imm", immediate, 8'h10);
      cmp1("halt_hold_we", reg_we, 1'b0);
      tick(); cmp8("halt_hold_pc", pc_shadow, 8'h10);
    end
    reset = 1'b1; #1;
    cmp8("halt_rst_pc", pc_shadow, 8'h00); cmp1("halt_rst_halted", halted, 1'b0);
    tick(); reset = 1'b0;

    // Reset during LD cycle A abandons writeback
    put(24'h430000, 1'b0); cmp1("ld0_re", mem_re, 1'b1);
    reset = 1'b1; #1;
    cmp1("ldrst_we", reg_we, 1'b0); cmp1("ldrst_pcsrc", PCSrc, 1'b0);
    tick(); cmp1("ldrst_we2", reg_we, 1'b0);
    tick(); cmp8("ldrst_pc", pc_shadow, 8'h00);
    reset = 1'b0;
    put(24'h430000, 1'b0);
    cmp1("ldre_we", reg_we, 1'b0); cmp1("ldre_re", mem_re, 1'b1);
    tick(); cmp8("pc_ldre", pc_shadow, 8'h00); cmp1("ldreB_we", reg_we, 1'b1);
    tick(); cmp8("pc_ldreB", pc_shadow, 8'h01);

    // Mixed traffic checked by the model only
    for (int k = 0; k < 300; k++) begin
      r  = $urandom;
      op = 4'($urandom_range(0, 14));
      put({op, r[19:0]}, r[31]);
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 SHALL have CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-002 SHALL have reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have instr  input  24  instruction from fetch ROM at current PC; combinational, same cycle.
REQ-004 SHALL have alu_zero  input  1  ALU result-is-zero, valid in the cycle of the executing instruction.
REQ-005 SHALL have PCSrc  output  1  1 = fetch loads immediate into PC at next edge; 0 = PC+1.
REQ-006 SHALL have immediate  output  8  next-PC target when PCSrc=1.
REQ-007 SHALL have rd_addr, rs_addr, rt_addr  output  4 each  register file addresses = instr[19:16], [15:12], [11:8].
REQ-008 SHALL have imm_data  output  8  instr[7:0], ALU immediate operand.
REQ-009 SHALL have alu_op  output  2  00 ADD, 01 SUB, 10 pass-B, 11 unused.
REQ-010 SHALL have alu_src_imm, reg_we, mem_re, mem_we, wb_sel  output  1 each  B-operand select, regfile write, data-mem read, data-mem write, writeback select (1 = memory).
REQ-011 SHALL have halted  output  1  registered, high while in HALT.
REQ-012 SHALL have pc_shadow  output  8  registered copy of the fetch PC.

Function
REQ-013 SHALL decode opcode = instr[23:20]: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LD, 5 ST, 6 JMP, 7 BEQ, 8 BNE, 9 CMP, F HALT; opcodes A-E SHALL behave as NOP.
REQ-014 SHALL drive all control outputs combinationally from instr, state and z_flag; default every enable 0, PCSrc 0, alu_op 00.
REQ-015 SHALL hold state machine {RUN, LOAD_WB, HALT}, flag register z_flag, and pc_shadow as the only registers.
REQ-016 SHALL update pc_shadow each edge to (PCSrc ? immediate : pc_shadow+1), mod 256 (255 -> 0 wraps).
REQ-017 SHALL stall fetch by driving PCSrc=1, immediate=pc_shadow (re-fetch same address); no other stall mechanism exists.
REQ-018 RUN, ADD/SUB: alu_op 00/01, alu_src_imm 0, reg_we 1, wb_sel 0; SUB also loads z_flag <= alu_zero.
REQ-019 RUN, ADDI: alu_op 00, alu_src_imm 1, reg_we 1.
REQ-020 RUN, CMP: alu_op 01, reg_we 0, z_flag <= alu_zero.
REQ-021 RUN, ST: mem_we 1, alu_op 10, single cycle.
REQ-022 RUN, JMP: PCSrc 1, immediate = instr[7:0].
REQ-023 RUN, BEQ/BNE: PCSrc = z_flag / ~z_flag, immediate = instr[7:0]; uses z_flag registered before this cycle, so CMP immediately followed by BEQ sees the CMP result.
REQ-024 RUN, LD: mem_re 1, reg_we 0, stall per REQ-017, next state LOAD_WB.
REQ-025 LOAD_WB (same LD re-presented): mem_re 1, wb_sel 1, reg_we 1, PCSrc 0, next state RUN; LD latency is therefore 2 cycles, all others 1.
REQ-026 LOAD_WB with instr opcode not LD (corrupt ROM) SHALL still complete writeback and return to RUN.
REQ-027 RUN, HALT: stall per REQ-017, next state HALT; HALT state holds stall forever, all enables 0, exits only on reset.
REQ-028 Branch/JMP target equal to pc_shadow SHALL be legal (self-loop), no special handling.

Reset
REQ-029 On reset assertion, asynchronously: state RUN, z_flag 0, pc_shadow 0, halted 0.
REQ-030 While reset high, all enables and PCSrc SHALL be 0; reset mid-LD SHALL abandon writeback without asserting reg_we.
REQ-031 First instruction executed after reset release SHALL be address 0.

Verification
REQ-032 ADDI r1,5 at 0; ADD at 1 -> reg_we 1 both cycles, alu_src_imm 1 then 0, pc_shadow 0,1,2.
REQ-033 LD at addr 3 -> cycle A: mem_re 1, PCSrc 1, immediate 03; cycle B: reg_we 1, wb_sel 1; pc_shadow 3,3,4.
REQ-034 CMP with alu_zero=1 then BEQ 0x40 -> PCSrc 1, pc_shadow 0x40; same with alu_zero=0 -> pc_shadow +1; BNE inverse.
REQ-035 JMP 0x00 at address 0xFF, and NOP at 0xFF -> both yield pc_shadow 0x00.
REQ-036 HALT at 0x10 -> halted 1, PCSrc 1, immediate 0x10 for 20+ cycles; reset -> pc_shadow 0, halted 0.
REQ-037 Assert reset during LD cycle A -> no reg_we pulse, state RUN, pc_shadow 0.
